// File: rtl/slave_fifo_pkg.sv
// Shared constants and helpers for the slave channel buffer.
// Default sizes, pointer-width helper and the default slack/count field type.
package slave_fifo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_CNT_W  = 16;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [ptr_w(DEF_DEPTH):0] slack_t;

endpackage

// File: rtl/slave_fifo_chan_mem.sv
// DEPTH x DATA_W register array: sync write port, async read port.
// Ports: clk, we, waddr, wdata (write); raddr, rdata (read). No reset.
module sfifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/slave_fifo_chan.sv
// Slave channel buffer: valid/ready FIFO with enable, flush, almost-full
// and a saturating accepted-word counter. Ports: up_* in, dn_* out, status.
module slave_fifo_chan
  import slave_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PTR_W     = ptr_w(DEPTH),
  parameter int AF_THRESH = DEPTH - 2,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ch_en,
  input  logic              flush,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  output logic              up_ready,
  output logic              dn_valid,
  output logic [DATA_W-1:0] dn_data,
  input  logic              dn_ready,
  output logic [PTR_W:0]    fifo_slack,
  output logic              almost_full,
  output logic [CNT_W-1:0]  wr_count
);

  typedef logic [PTR_W:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AF_C    = cnt_t'(AF_THRESH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  cnt_t              count_q, count_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              af_q;
  logic              full, empty;
  logic              wr_fire, rd_fire;
  logic [DATA_W-1:0] rdata;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign up_ready = rst_n & ch_en & ~full & ~flush;
  assign wr_fire  = up_valid & up_ready;
  assign dn_valid = ~empty;
  assign rd_fire  = dn_valid & dn_ready & ~flush;

  sfifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr_q),
    .wdata (up_data),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_cnt_d = wr_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      wr_cnt_d = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (wr_fire && (wr_cnt_q != '1))
        wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_cnt_q <= '0;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_cnt_q <= wr_cnt_d;
      af_q     <= (count_d >= AF_C);
    end
  end

  assign dn_data     = dn_valid ? rdata : '0;
  assign fifo_slack  = DEPTH_C - count_q;
  assign almost_full = af_q;
  assign wr_count    = wr_cnt_q;

  // A stalled upstream word must not change until taken or withdrawn.
  a_up_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    (up_valid && !up_ready) |=> (!up_valid || $stable(up_data))
  );

endmodule

// File: tb/tb_slave_fifo_chan.sv
// Self-checking bench for slave_fifo_chan against a queue-based model.
// Directed scenarios followed by randomized traffic.
module tb_slave_fifo_chan;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int PW    = 3;
  localparam int CW    = 5;
  localparam int AFT   = DEPTH - 2;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ch_en = 1'b1;
  logic          flush = 1'b0;
  logic          up_valid = 1'b0;
  logic [DW-1:0] up_data = '0;
  logic          up_ready;
  logic          dn_valid;
  logic [DW-1:0] dn_data;
  logic          dn_ready = 1'b0;
  logic [PW:0]   fifo_slack;
  logic          almost_full;
  logic [CW-1:0] wr_count;

  slave_fifo_chan #(
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .AF_THRESH (AFT),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_en       (ch_en),
    .flush       (flush),
    .up_valid    (up_valid),
    .up_data     (up_data),
    .up_ready    (up_ready),
    .dn_valid    (dn_valid),
    .dn_data     (dn_data),
    .dn_ready    (dn_ready),
    .fifo_slack  (fifo_slack),
    .almost_full (almost_full),
    .wr_count    (wr_count)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] q[$];
  int            wc = 0;
  logic          stall = 1'b0;

  function automatic logic m_ready();
    return rst_n & ch_en & (q.size() < DEPTH) & ~flush;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [DW-1:0] ed;
    ed = (q.size() != 0) ? q[0] : '0;
    chk("up_ready", 32'(up_ready), 32'(m_ready()));
    chk("dn_valid", 32'(dn_valid), 32'(q.size() != 0));
    chk("dn_data", dn_data, ed);
    chk("fifo_slack", 32'(fifo_slack), 32'(DEPTH - q.size()));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AFT));
    chk("wr_count", 32'(wr_count), 32'(wc));
  endtask

  task automatic cyc();
    logic wr, rd;
    @(negedge clk);
    check_all();
    wr    = up_valid & m_ready();
    rd    = (q.size() != 0) & dn_ready & ~flush;
    stall = up_valid & ~m_ready();
    @(posedge clk);
    if (!rst_n || flush) begin
      q.delete();
      wc = 0;
    end else begin
      if (rd) void'(q.pop_front());
      if (wr) begin
        q.push_back(up_data);
        if (wc != MAXC) wc++;
      end
    end
    #1;
  endtask

  task automatic set_in(input logic v, input logic [DW-1:0] d,
                        input logic r, input logic en,
                        input logic fl);
    up_valid = v;
    if (!stall) up_data = d;
    dn_ready = r;
    ch_en    = en;
    flush    = fl;
  endtask

  initial begin
    // reset held for a few cycles, checked while asserted
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // fill to full, then a 9th offer is refused
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b1, 1'b0);
      cyc();
    end
    set_in(1'b1, 32'hA8, 1'b0, 1'b1, 1'b0);
    cyc();
    cyc();

    // drain in order
    for (int i = 0; i < 9; i++) begin
      set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      cyc();
    end

    // flush, then streaming read/write for 20 cycles
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    cyc();
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 32'h100 + 32'(i), 1'b1, 1'b1, 1'b0);
      cyc();
    end
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc();
    cyc();

    // 5 stored, channel disabled, drain, then flush 3 stored
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b1, 1'b0);
      cyc();
    end
    set_in(1'b1, 32'hBF, 1'b0, 1'b0, 1'b0);
    cyc();
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 32'hBF, 1'b1, 1'b0, 1'b0);
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b1, 1'b0);
      cyc();
    end
    set_in(1'b1, 32'hCF, 1'b1, 1'b1, 1'b1);
    cyc();
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc();

    // async reset mid-burst with 4 stored
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'hD0 + 32'(i), 1'b0, 1'b1, 1'b0);
      cyc();
    end
    set_in(1'b1, 32'hD4, 1'b0, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    q.delete();
    wc = 0;
    #1;
    check_all();
    cyc();
    rst_n = 1'b1;
    set_in(1'b1, 32'hE5, 1'b0, 1'b1, 1'b0);
    cyc();
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc();
    cyc();

    // random traffic without flush long enough to saturate wr_count
    for (int i = 0; i < 150; i++) begin
      set_in($urandom_range(0, 9) < 8, $urandom,
             $urandom_range(0, 9) < 6,
             $urandom_range(0, 9) != 0, 1'b0);
      cyc();
    end
    // random traffic with occasional flush
    for (int i = 0; i < 200; i++) begin
      set_in($urandom_range(0, 9) < 6, $urandom,
             $urandom_range(0, 9) < 6,
             $urandom_range(0, 9) != 0,
             $urandom_range(0, 29) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
